// File: rtl/note_map_sequencer_if.sv
// Pattern-ROM and note-lane bus of the note map sequencer.
// Handshake: there is no valid/ready pair on this bus. rom_data must hold the row
// addressed by rom_addr one clk after rom_addr was presented (synchronous ROM), and
// map/step are single-cycle strobes that downstream lanes must accept without backpressure.
interface note_map_sequencer_if #(
    parameter int LANES = 6,
    parameter int AW    = 6
);
    logic             start;
    logic             pause;
    logic [AW-1:0]    rom_addr;
    logic [LANES-1:0] rom_data;
    logic [LANES-1:0] map;
    logic             step;
    logic [AW-1:0]    beat_idx;
    logic             playing;
    logic             done;
    logic [1:0]       state_dbg;

    // Sequencer side: owns the ROM address and the lane strobes.
    modport master (
        input  start, pause, rom_data,
        output rom_addr, map, step, beat_idx, playing, done, state_dbg
    );

    // Environment side: game controller, pattern ROM and lane generators.
    modport slave (
        output start, pause, rom_data,
        input  rom_addr, map, step, beat_idx, playing, done, state_dbg
    );
endinterface

// File: rtl/note_map_sequencer.sv
// Walks a song pattern ROM at a fixed step rate and emits one-cycle per-lane map
// strobes for every row, plus play/pause/done status for the game controller.
module note_map_sequencer #(
    parameter int LANES    = 6,
    parameter int TICK_DIV = 2500000,
    parameter int SONG_LEN = 64,
    parameter int AW       = 6,
    parameter int LOOP     = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    note_map_sequencer_if.master  bus
);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] TICK_LAST = DW'(TICK_DIV - 1);
    localparam logic [AW-1:0] LAST_ROW  = AW'(SONG_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [DW-1:0]    div;
    logic [AW-1:0]    rom_addr_q;
    logic [AW-1:0]    beat_idx_q;
    logic [LANES-1:0] map_q;
    logic             step_q;
    logic             playing_q;
    logic             done_q;

    assign bus.rom_addr  = rom_addr_q;
    assign bus.map       = map_q;
    assign bus.step      = step_q;
    assign bus.beat_idx  = beat_idx_q;
    assign bus.playing   = playing_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state;

    // Sequencer FSM: start/restart, one ROM-latency prime cycle, paced row stepping, end of song.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            div        <= '0;
            rom_addr_q <= '0;
            beat_idx_q <= '0;
            map_q      <= '0;
            step_q     <= 1'b0;
            playing_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Strobes live for exactly one cycle after a tick edge.
            map_q  <= '0;
            step_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state      <= PRIME;
                        rom_addr_q <= '0;
                        div        <= '0;
                        beat_idx_q <= '0;
                        playing_q  <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                PRIME: begin
                    // Row 0 is being read during this cycle; it is valid in PLAY.
                    state <= PLAY;
                    div   <= '0;
                end
                PLAY: begin
                    // A paused cycle freezes the divider, so a tick due on that edge is deferred.
                    if (!bus.pause) begin
                        if (div == TICK_LAST) begin
                            div        <= '0;
                            map_q      <= bus.rom_data;
                            step_q     <= 1'b1;
                            beat_idx_q <= rom_addr_q;
                            if (rom_addr_q != LAST_ROW) begin
                                rom_addr_q <= rom_addr_q + AW'(1);
                            end else if (LOOP != 0) begin
                                rom_addr_q <= '0;
                            end else begin
                                // done rises together with the final map pulse.
                                state     <= DONE;
                                playing_q <= 1'b0;
                                done_q    <= 1'b1;
                            end
                        end else begin
                            div <= div + DW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_note_map_sequencer.sv
// Bench for note_map_sequencer: one LOOP=0 and one LOOP=1 instance share the stimulus,
// each fed by its own one-cycle pattern ROM, compared against a row/tick counting model.
module tb_note_map_sequencer;
    localparam int TD = 4;
    localparam int SL = 4;
    localparam int LN = 6;
    localparam int AWB = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start_s = 1'b0;
    logic pause_s = 1'b0;
    logic [LN-1:0] rom_rows [SL];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    note_map_sequencer_if #(.LANES(LN), .AW(AWB)) bus0 ();
    note_map_sequencer_if #(.LANES(LN), .AW(AWB)) bus1 ();

    assign bus0.start = start_s;
    assign bus0.pause = pause_s;
    assign bus1.start = start_s;
    assign bus1.pause = pause_s;

    note_map_sequencer #(.LANES(LN), .TICK_DIV(TD), .SONG_LEN(SL), .AW(AWB), .LOOP(0)) dut0 (
        .clk(clk), .resetn(resetn), .bus(bus0)
    );
    note_map_sequencer #(.LANES(LN), .TICK_DIV(TD), .SONG_LEN(SL), .AW(AWB), .LOOP(1)) dut1 (
        .clk(clk), .resetn(resetn), .bus(bus1)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Synchronous pattern ROMs: row appears one clk after its address.
    always_ff @(posedge clk) begin
        bus0.rom_data <= rom_rows[bus0.rom_addr];
        bus1.rom_data <= rom_rows[bus1.rom_addr];
    end

    // ---------------- reference model ----------------
    // Song position is counted in rows played and unpaused playing cycles.
    bit          on   [2];
    bit          prm  [2];
    bit          fin  [2];
    int          unp  [2];
    int          rows [2];
    logic [LN-1:0] em [2];
    logic        es   [2];
    logic [AWB-1:0] eb [2];

    function automatic void model_clear();
        for (int k = 0; k < 2; k++) begin
            on[k] = 0; prm[k] = 0; fin[k] = 0; unp[k] = 0; rows[k] = 0;
            em[k] = '0; es[k] = 1'b0; eb[k] = '0;
        end
    endfunction

    function automatic void model_step(input logic st, input logic pa);
        for (int k = 0; k < 2; k++) begin
            em[k] = '0;
            es[k] = 1'b0;
            if (prm[k]) begin
                prm[k] = 0;
            end else if (on[k]) begin
                if (!pa) begin
                    unp[k]++;
                    if (unp[k] % TD == 0) begin
                        em[k] = rom_rows[rows[k] % SL];
                        es[k] = 1'b1;
                        eb[k] = AWB'(rows[k] % SL);
                        rows[k]++;
                        if (k == 0 && rows[k] == SL) begin
                            on[k] = 0;
                            fin[k] = 1;
                        end
                    end
                end
            end else if (st) begin
                on[k] = 1; prm[k] = 1; fin[k] = 0; unp[k] = 0; rows[k] = 0; eb[k] = '0;
            end
        end
    endfunction

    function automatic logic [25:0] exp_vec();
        logic [AWB-1:0] ea [2];
        for (int k = 0; k < 2; k++) begin
            if (on[k]) ea[k] = AWB'(rows[k] % SL);
            else if (fin[k]) ea[k] = AWB'(SL - 1);
            else ea[k] = '0;
        end
        return {em[0], es[0], eb[0], on[0], fin[0], ea[0],
                em[1], es[1], eb[1], on[1], fin[1], ea[1]};
    endfunction

    function automatic logic [25:0] obs_vec();
        return {bus0.map, bus0.step, bus0.beat_idx, bus0.playing, bus0.done, bus0.rom_addr,
                bus1.map, bus1.step, bus1.beat_idx, bus1.playing, bus1.done, bus1.rom_addr};
    endfunction

    // ---------------- driver tasks ----------------
    function automatic void default_rows();
        rom_rows[0] = 6'b000001;
        rom_rows[1] = 6'b000010;
        rom_rows[2] = 6'b100000;
        rom_rows[3] = 6'b111111;
    endfunction

    // Called at a negedge; holds cycle inputs, advances one clk, returns at the next negedge.
    task automatic run_cycle(input logic st, input logic pa);
        start_s = st;
        pause_s = pa;
        @(posedge clk);
        if (resetn) model_step(st, pa);
        else model_clear();
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        start_s = 1'b0;
        pause_s = 1'b0;
        model_clear();
        @(negedge clk);
        resetn = 1'b1;
        cyc = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn = 1'b0;
        model_clear();
        @(negedge clk);
        n_cmp++;
        if (obs_vec() !== 26'd0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h exp=%h", obs_vec(), 26'd0);
        end
        resetn = 1'b1;
        cyc = 0;
    endtask

    task automatic test_basic();
        logic [LN-1:0] want;
        apply_reset();
        for (int c = 0; c < 21; c++) begin
            run_cycle(c == 0, 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL basic_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (cyc == 6 || cyc == 10 || cyc == 14 || cyc == 18) begin
                want = (cyc == 6) ? 6'b000001 : (cyc == 10) ? 6'b000010 :
                       (cyc == 14) ? 6'b100000 : 6'b111111;
                n_cmp++;
                if ({bus0.step, bus0.map, bus0.beat_idx} !== {1'b1, want, AWB'((cyc - 6) / 4)}) begin
                    n_err++;
                    $display("FAIL basic_pulse cyc=%0d got=%b/%b/%0d exp=1/%b/%0d", cyc,
                             bus0.step, bus0.map, bus0.beat_idx, want, (cyc - 6) / 4);
                end
            end
            if (cyc >= 18) begin
                n_cmp++;
                if ({bus0.done, bus0.playing} !== 2'b10) begin
                    n_err++;
                    $display("FAIL basic_done cyc=%0d got=%b%b exp=10", cyc, bus0.done, bus0.playing);
                end
            end
        end
    endtask

    task automatic test_pause();
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            run_cycle(c == 0, (c >= 4 && c <= 9));
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL pause_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (cyc >= 2 && cyc <= 17) begin
                n_cmp++;
                if (bus0.step !== (cyc == 12 || cyc == 16)) begin
                    n_err++;
                    $display("FAIL pause_sched cyc=%0d got=%b exp=%b", cyc, bus0.step, (cyc == 12 || cyc == 16));
                end
            end
        end
    endtask

    task automatic test_loop();
        apply_reset();
        for (int c = 0; c < 24; c++) begin
            run_cycle(c == 0, 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL loop_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (cyc == 22) begin
                n_cmp++;
                if ({bus1.step, bus1.map, bus1.beat_idx, bus1.done} !== {1'b1, 6'b000001, 2'd0, 1'b0}) begin
                    n_err++;
                    $display("FAIL loop_wrap got=%b/%b/%0d/%b exp=1/000001/0/0",
                             bus1.step, bus1.map, bus1.beat_idx, bus1.done);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int c = 0; c < 8; c++) run_cycle(c == 0, 1'b0);
        resetn = 1'b0;
        model_clear();
        #1;
        n_cmp++;
        if ({bus0.map, bus0.step, bus0.playing, bus0.rom_addr, bus0.beat_idx,
             bus1.map, bus1.step, bus1.playing, bus1.rom_addr, bus1.beat_idx} !== '0) begin
            n_err++;
            $display("FAIL reset_mid got=%h exp=0", obs_vec());
        end
        @(negedge clk);
        resetn = 1'b1;
        cyc = 0;
        for (int c = 0; c < 8; c++) begin
            run_cycle(c == 0, 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL reset_mid_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (cyc == 6) begin
                n_cmp++;
                if ({bus0.step, bus0.map} !== {1'b1, 6'b000001}) begin
                    n_err++;
                    $display("FAIL reset_mid_restart got=%b/%b exp=1/000001", bus0.step, bus0.map);
                end
            end
        end
    endtask

    task automatic test_restart();
        apply_reset();
        for (int c = 0; c < 28; c++) begin
            run_cycle(c == 0 || c == 7 || c == 20, 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL restart_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (cyc == 10) begin
                n_cmp++;
                if ({bus0.step, bus0.beat_idx} !== {1'b1, 2'd1}) begin
                    n_err++;
                    $display("FAIL restart_ignored got=%b/%0d exp=1/1", bus0.step, bus0.beat_idx);
                end
            end
            if (cyc == 21) begin
                n_cmp++;
                if ({bus0.done, bus0.playing} !== 2'b01) begin
                    n_err++;
                    $display("FAIL restart_done_drop got=%b%b exp=01", bus0.done, bus0.playing);
                end
            end
            if (cyc == 26) begin
                n_cmp++;
                if ({bus0.step, bus0.map, bus0.beat_idx} !== {1'b1, 6'b000001, 2'd0}) begin
                    n_err++;
                    $display("FAIL restart_first got=%b/%b/%0d exp=1/000001/0",
                             bus0.step, bus0.map, bus0.beat_idx);
                end
            end
        end
    endtask

    task automatic test_zero_row();
        apply_reset();
        rom_rows[1] = 6'b000000;
        for (int c = 0; c < 12; c++) begin
            run_cycle(c == 0, 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL zero_row_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (cyc == 10) begin
                n_cmp++;
                if ({bus0.step, bus0.map, bus0.rom_addr} !== {1'b1, 6'b000000, 2'd2}) begin
                    n_err++;
                    $display("FAIL zero_row got=%b/%b/%0d exp=1/000000/2",
                             bus0.step, bus0.map, bus0.rom_addr);
                end
            end
        end
        default_rows();
    endtask

    task automatic test_random();
        apply_reset();
        for (int r = 0; r < SL; r++) rom_rows[r] = LN'($urandom_range(0, 63));
        for (int c = 0; c < 400; c++) begin
            run_cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        default_rows();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        default_rows();
        model_clear();
        test_reset();
        test_basic();
        test_pause();
        test_loop();
        test_reset_mid();
        test_restart();
        test_zero_row();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
